// File: rtl/fetch_req_ctrl_pkg.sv
// rtl/fetch_req_ctrl_pkg.sv - shared state codes, PC defaults and types for the pre-fetch sequencer
package fetch_req_ctrl_pkg;

  localparam logic [1:0] FS_BOOT = 2'd0;
  localparam logic [1:0] FS_REQ  = 2'd1;
  localparam logic [1:0] FS_WAIT = 2'd2;
  localparam logic [1:0] FS_HOLD = 2'd3;

  localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_PC   = 32'hBFC0_0380;

  // Redirect target parked while an address phase cannot be abandoned.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
  } pend_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_req_ctrl_next_pc_sel.sv
// rtl/fetch_req_ctrl_next_pc_sel.sv - priority mux of redirect sources (exc > eret > br) plus sequential pc+4
module fetch_req_ctrl_next_pc_sel
  import fetch_req_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_PC = DEF_EXC_PC
) (
  input  logic        i_exc,
  input  logic        i_eret,
  input  logic [31:0] i_eret_pc,
  input  logic        i_br,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_pc,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_pc4
);

  always_comb begin
    o_redirect = i_exc | i_eret | i_br;
    o_target   = i_br_target;
    if (i_eret) o_target = i_eret_pc;
    if (i_exc)  o_target = EXC_PC;
    o_pc4      = pc_inc(i_pc);
  end

endmodule

// File: rtl/fetch_req_ctrl.sv
// rtl/fetch_req_ctrl.sv - pre-fetch sequencer: owns the fetch PC, drives the instruction bus,
// cancels stale responses on redirect and holds one instruction for the fetch stage.
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_flush,
  input  logic        eret_flush,
  input  logic [31:0] eret_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        fs_allowin,
  output logic        to_fs_valid,
  output logic [31:0] to_fs_pc,
  output logic [31:0] to_fs_inst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  pend_t       r_pend;
  logic        r_cancel;
  logic [31:0] r_hold_inst;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_deliver;

  fetch_req_ctrl_next_pc_sel #(.EXC_PC(EXC_PC)) u_next_pc_sel (
    .i_exc       (exc_flush),
    .i_eret      (eret_flush),
    .i_eret_pc   (eret_pc),
    .i_br        (br_taken),
    .i_br_target (br_target),
    .i_pc        (r_pc),
    .o_redirect  (w_redirect),
    .o_target    (w_target),
    .o_pc4       (w_pc4)
  );

  // r_pc always names the outstanding fetch, so it doubles as the offered PC.
  assign w_deliver   = (r_state == FS_WAIT) && inst_data_ok && !r_cancel && !w_redirect;
  assign to_fs_valid = w_deliver || ((r_state == FS_HOLD) && !w_redirect);
  assign to_fs_pc    = r_pc;
  assign to_fs_inst  = (r_state == FS_HOLD) ? r_hold_inst : inst_rdata;
  assign inst_req    = (r_state == FS_REQ);
  assign inst_addr   = r_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= FS_BOOT;
      r_pc        <= RESET_PC;
      r_pend      <= '0;
      r_cancel    <= 1'b0;
      r_hold_inst <= '0;
    end else begin
      case (r_state)
        FS_BOOT: r_state <= FS_REQ;
        FS_REQ: begin
          if (inst_addr_ok) begin
            r_state  <= FS_WAIT;
            r_pend   <= '0;
            if (w_redirect) begin
              r_pc     <= w_target;
              r_cancel <= 1'b1;
            end else if (r_pend.vld) begin
              r_pc     <= r_pend.pc;
              r_cancel <= 1'b1;
            end
          end else if (w_redirect) begin
            // Address must stay stable until accepted; park the newest target.
            r_pend <= '{vld: 1'b1, pc: w_target};
          end
        end
        FS_WAIT: begin
          if (inst_data_ok) begin
            r_cancel <= 1'b0;
            if (w_redirect) begin
              r_pc    <= w_target;
              r_state <= FS_REQ;
            end else if (r_cancel) begin
              r_state <= FS_REQ;
            end else if (fs_allowin) begin
              r_pc    <= w_pc4;
              r_state <= FS_REQ;
            end else begin
              r_hold_inst <= inst_rdata;
              r_state     <= FS_HOLD;
            end
          end else if (w_redirect) begin
            r_cancel <= 1'b1;
            r_pc     <= w_target;
          end
        end
        default: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= FS_REQ;
          end else if (fs_allowin) begin
            r_pc    <= w_pc4;
            r_state <= FS_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// tb/tb_fetch_req_ctrl.sv - scoreboard bench for fetch_req_ctrl
module tb_fetch_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exc_flush, eret_flush, br_taken, fs_allowin;
  logic [31:0] eret_pc, br_target;
  logic        to_fs_valid, inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] to_fs_pc, to_fs_inst, inst_addr, inst_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];

  bit          bus_out = 1'b0;
  logic [31:0] bus_addr = '0;

  always #5 clk = ~clk;

  fetch_req_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .exc_flush    (exc_flush),
    .eret_flush   (eret_flush),
    .eret_pc      (eret_pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .fs_allowin   (fs_allowin),
    .to_fs_valid  (to_fs_valid),
    .to_fs_pc     (to_fs_pc),
    .to_fs_inst   (to_fs_inst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_dlv(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_inst_q.push_back(mem(pc));
  endtask

  // One clock: drive this cycle's inputs after the edge, then score the handshakes.
  task automatic cyc(input bit a_en, input bit d_en, input bit allow,
                     input bit exc, input bit eret, input bit br,
                     input logic [31:0] e_pc, input logic [31:0] b_tgt);
    @(posedge clk);
    #1;
    fs_allowin   = allow;
    exc_flush    = exc;
    eret_flush   = eret;
    br_taken     = br;
    eret_pc      = e_pc;
    br_target    = b_tgt;
    inst_addr_ok = a_en && inst_req;
    inst_data_ok = d_en && bus_out;
    inst_rdata   = inst_data_ok ? mem(bus_addr) : 32'hDEAD_BEEF;
    #1;
    if (inst_req && inst_addr_ok) begin
      chk("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) chk("req_addr", inst_addr, exp_addr_q.pop_front());
      bus_out  = 1'b1;
      bus_addr = inst_addr;
    end
    if (to_fs_valid && fs_allowin) begin
      chk("dlv_expected", 32'(exp_pc_q.size() != 0), 32'd1);
      if (exp_pc_q.size() != 0) begin
        chk("dlv_pc", to_fs_pc, exp_pc_q.pop_front());
        chk("dlv_inst", to_fs_inst, exp_inst_q.pop_front());
      end
    end
    if (inst_data_ok) bus_out = 1'b0;
  endtask

  task automatic idle(input bit a_en, input bit d_en, input bit allow);
    cyc(a_en, d_en, allow, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_req_q"}, 32'(exp_addr_q.size()), 32'd0);
    chk({tag, "_dlv_q"}, 32'(exp_pc_q.size()), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    {exc_flush, eret_flush, br_taken, fs_allowin, inst_addr_ok, inst_data_ok} = '0;
    eret_pc = '0; br_target = '0; inst_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_valid", 32'(to_fs_valid), 32'd0);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    resetn = 1'b1;
    #1;
    chk("boot_req", 32'(inst_req), 32'd0);

    // sequential fetch, single-cycle bus, fetch stage always ready
    push_req(32'hBFC0_0000); push_req(32'hBFC0_0004); push_req(32'hBFC0_0008);
    push_dlv(32'hBFC0_0000); push_dlv(32'hBFC0_0004); push_dlv(32'hBFC0_0008);
    repeat (6) idle(1'b1, 1'b1, 1'b1);
    queues_empty("seq");

    // fetch stage stalls: instruction parked in HOLD
    push_req(32'hBFC0_000C); push_req(32'hBFC0_0010);
    push_dlv(32'hBFC0_000C); push_dlv(32'hBFC0_0010);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1'b1, 1'b1, 1'b0);
      chk("hold_valid", 32'(to_fs_valid), 32'd1);
      chk("hold_req", 32'(inst_req), 32'd0);
      chk("hold_pc", to_fs_pc, 32'hBFC0_000C);
      chk("hold_inst", to_fs_inst, mem(32'hBFC0_000C));
    end
    repeat (3) idle(1'b1, 1'b1, 1'b1);
    queues_empty("hold");

    // branch while waiting for data: response dropped
    push_req(32'hBFC0_0014); push_req(32'h8000_0100);
    push_dlv(32'h8000_0100);
    idle(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, 32'h8000_0100);
    chk("br_wait_valid", 32'(to_fs_valid), 32'd0);
    idle(1'b1, 1'b1, 1'b1);
    chk("br_drop_dok", 32'(inst_data_ok), 32'd1);
    chk("br_drop_valid", 32'(to_fs_valid), 32'd0);
    repeat (2) idle(1'b1, 1'b1, 1'b1);
    queues_empty("br");

    // exception and branch together in HOLD: exception wins
    push_req(32'h8000_0104); push_req(32'hBFC0_0380);
    push_dlv(32'hBFC0_0380);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, 32'h8000_0200);
    chk("exc_hold_valid", 32'(to_fs_valid), 32'd0);
    idle(1'b1, 1'b1, 1'b1);
    chk("exc_req", 32'(inst_req), 32'd1);
    chk("exc_addr", inst_addr, 32'hBFC0_0380);
    idle(1'b1, 1'b1, 1'b1);
    queues_empty("exc");

    // eret while address phase is stalled
    push_req(32'hBFC0_0384); push_req(32'h8000_2000);
    push_dlv(32'h8000_2000);
    idle(1'b0, 1'b0, 1'b1);
    chk("eret_addr_c1", inst_addr, 32'hBFC0_0384);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_2000, '0);
    chk("eret_addr_c2", inst_addr, 32'hBFC0_0384);
    for (int i = 0; i < 2; i++) begin
      idle(1'b0, 1'b0, 1'b1);
      chk("eret_addr_stable", inst_addr, 32'hBFC0_0384);
      chk("eret_req_held", 32'(inst_req), 32'd1);
    end
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    chk("eret_drop_valid", 32'(to_fs_valid), 32'd0);
    repeat (2) idle(1'b1, 1'b1, 1'b1);
    queues_empty("eret");

    // asynchronous reset while a fetch is outstanding
    push_req(32'h8000_2004);
    idle(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #3;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = mem(bus_addr);
    resetn       = 1'b0;
    #1;
    chk("arst_req", 32'(inst_req), 32'd0);
    chk("arst_valid", 32'(to_fs_valid), 32'd0);
    chk("arst_addr", inst_addr, 32'hBFC0_0000);
    inst_data_ok = 1'b0;
    bus_out      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    push_req(32'hBFC0_0000);
    push_dlv(32'hBFC0_0000);
    idle(1'b1, 1'b1, 1'b1);
    idle(1'b1, 1'b1, 1'b1);
    queues_empty("arst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
